// File: rtl/result_streamer_if.sv
// Beat-level valid/ready stream carrying one result element plus its coordinates.
interface result_streamer_if #(
    parameter int IW = 2
);
    logic          m_valid;
    logic          m_ready;
    logic [31:0]   m_data;
    logic [IW-1:0] m_row;
    logic [IW-1:0] m_col;
    logic          m_last;

    modport master (output m_valid, m_data, m_row, m_col, m_last, input m_ready);
    modport slave  (input m_valid, m_data, m_row, m_col, m_last, output m_ready);
endinterface

// File: rtl/result_streamer.sv
// Captures the controller's n*n result on an out_ready rising edge and streams it
// row-major, one element per handshake, with coordinates, last flag and running checksum.
module result_streamer #(
    parameter int n  = 4,
    parameter int IW = (n > 1) ? $clog2(n) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [32*n*n:0]   in_matrix,
    input  logic              in_ready,
    result_streamer_if.master m,
    output logic              busy,
    output logic              done,
    output logic [31:0]       checksum,
    output logic              missed
);
    localparam int NE = n * n;
    localparam int XW = (NE > 1) ? $clog2(NE) : 1;

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    state_t              state_q, state_d;
    logic [NE-1:0][31:0] buf_q, buf_d;
    logic [XW-1:0]       idx_q, idx_d;
    logic [31:0]         cks_q, cks_d;
    logic                missed_q, missed_d;
    logic                in_ready_q;
    logic                rise, hs, last;
    logic                unused_msb;

    assign unused_msb = in_matrix[32*NE];
    assign rise       = in_ready && !in_ready_q;
    assign last       = (int'(idx_q) == NE - 1);

    // Beat fields come straight from buffer/idx so they are valid alongside m_valid.
    assign m.m_valid = (state_q == STREAM);
    assign m.m_data  = buf_q[idx_q];
    assign m.m_row   = IW'(int'(idx_q) / n);
    assign m.m_col   = IW'(int'(idx_q) % n);
    assign m.m_last  = (state_q == STREAM) && last;
    assign hs        = m.m_valid && m.m_ready;

    assign busy     = (state_q == STREAM) || (state_q == DONE);
    assign done     = (state_q == DONE);
    assign checksum = cks_q;
    assign missed   = missed_q;

    always_comb begin
        state_d  = state_q;
        buf_d    = buf_q;
        idx_d    = idx_q;
        cks_d    = cks_q;
        missed_d = missed_q | (rise && (state_q != IDLE));
        case (state_q)
            IDLE: begin
                if (rise) begin
                    buf_d   = in_matrix[32*NE-1:0];
                    idx_d   = '0;
                    cks_d   = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (hs) begin
                    cks_d = cks_q + m.m_data;
                    if (last) state_d = DONE;
                    else      idx_d   = idx_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            buf_q      <= '0;
            idx_q      <= '0;
            cks_q      <= '0;
            missed_q   <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            idx_q      <= idx_d;
            cks_q      <= cks_d;
            missed_q   <= missed_d;
            in_ready_q <= in_ready;
        end
    end
endmodule

// File: tb/tb_result_streamer.sv
// Directed bench for result_streamer at n=2: stream order, backpressure, wrap, missed edge, mid-stream reset.
module tb_result_streamer;
    localparam int N  = 2;
    localparam int IW = 1;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [32*N*N:0]  in_matrix = '0;
    logic             in_ready = 1'b0;
    logic             busy, done, missed;
    logic [31:0]      checksum;

    result_streamer_if #(.IW(IW)) m ();

    result_streamer #(.n(N), .IW(IW)) dut (
        .clk(clk), .reset(reset), .in_matrix(in_matrix), .in_ready(in_ready),
        .m(m), .busy(busy), .done(done), .checksum(checksum), .missed(missed)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int nb, done_cnt, done_cyc;
    logic [31:0] done_cks;
    logic [31:0] bd [8];
    logic [1:0]  brc[8];
    logic        bl [8];
    int          bc [8];
    logic        prev_stall;
    logic [31:0] prev_data;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        nb = 0; done_cnt = 0; done_cyc = -1; done_cks = '0; prev_stall = 1'b0;
    endtask

    // One clock: drive m_ready for the cycle, then sample and log handshakes/done.
    task automatic cycle(input logic rdy);
        @(posedge clk);
        #1 m.m_ready = rdy;
        #1;
        cyc++;
        if (prev_stall) chk("stall_hold", m.m_data, prev_data);
        prev_stall = m.m_valid && !rdy;
        prev_data  = m.m_data;
        if (m.m_valid && rdy && nb < 8) begin
            bd[nb] = m.m_data; brc[nb] = {m.m_row, m.m_col}; bl[nb] = m.m_last; bc[nb] = cyc;
            nb++;
        end
        if (done) begin
            done_cnt++; done_cyc = cyc; done_cks = checksum;
        end
    endtask

    task automatic arm(input logic [31:0] e3, e2, e1, e0);
        in_ready = 1'b0;
        cycle(1'b1);
        in_matrix = {1'b0, e3, e2, e1, e0};
        in_ready  = 1'b1;
        clear_log();
    endtask

    task automatic chk_beats(input string tag, input logic [31:0] e0, e1, e2, e3);
        logic [31:0] exp [4];
        exp = '{e0, e1, e2, e3};
        chk({tag, "_nbeats"}, nb, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_data%0d", tag, i), bd[i], exp[i]);
            chk($sformatf("%s_rc%0d", tag, i), brc[i], i);
        end
    endtask

    initial begin
        int c0;
        m.m_ready = 1'b0;
        clear_log();
        #12;
        chk("rst_valid", m.m_valid, 0);
        chk("rst_last", m.m_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_missed", missed, 0);
        chk("rst_cks", checksum, 0);
        chk("rst_data", m.m_data, 0);
        reset = 1'b1;

        // Basic: A*B with A=B=[[1,0],[1,1]] -> [[1,0],[2,1]]
        arm(32'd1, 32'd2, 32'd0, 32'd1);
        c0 = cyc;
        for (int i = 0; i < 6; i++) cycle(1'b1);
        chk_beats("basic", 1, 0, 2, 1);
        for (int i = 0; i < 4; i++) chk($sformatf("basic_last%0d", i), bl[i], (i == 3));
        chk("basic_first_cyc", bc[0], c0 + 1);
        chk("basic_done_cyc", done_cyc, c0 + 5);
        chk("basic_done_cnt", done_cnt, 1);
        chk("basic_cks", done_cks, 4);
        chk("basic_idle", busy, 0);

        // Backpressure
        arm(32'd4, 32'd3, 32'd2, 32'd1);
        begin
            logic pat [10];
            pat = '{1, 0, 0, 1, 0, 1, 1, 1, 1, 1};
            for (int i = 0; i < 10; i++) cycle(pat[i]);
        end
        chk_beats("bp", 1, 2, 3, 4);
        chk("bp_done_cnt", done_cnt, 1);
        chk("bp_cks", done_cks, 10);
        chk("bp_cks_hold", checksum, 10);

        // Wrap-around checksum; input changes after capture are ignored
        arm(32'd3, 32'd2, 32'd1, 32'hFFFF_FFFF);
        cycle(1'b1);
        in_matrix = {1'b0, {4{32'hAAAA_AAAA}}};
        for (int i = 0; i < 6; i++) cycle(1'b1);
        chk_beats("wrap", 32'hFFFF_FFFF, 1, 2, 3);
        chk("wrap_cks", done_cks, 5);
        chk("wrap_missed", missed, 0);

        // Missed edge during beat 2
        arm(32'd40, 32'd30, 32'd20, 32'd10);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1);
            if (i == 1) in_ready = 1'b0;
            if (i == 2) in_ready = 1'b1;
        end
        chk_beats("miss", 10, 20, 30, 40);
        chk("miss_flag", missed, 1);
        chk("miss_done_cnt", done_cnt, 1);
        chk("miss_cks", done_cks, 100);
        chk("miss_idle", busy, 0);

        // Reset after two beats with in_ready held high
        arm(32'd8, 32'd7, 32'd6, 32'd5);
        cycle(1'b1);
        cycle(1'b1);
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("mrst_valid", m.m_valid, 0);
        chk("mrst_cks", checksum, 0);
        chk("mrst_missed", missed, 0);
        chk("mrst_busy", busy, 0);
        #3 reset = 1'b1;
        clear_log();
        c0 = cyc;
        for (int i = 0; i < 7; i++) cycle(1'b1);
        chk_beats("rest", 5, 6, 7, 8);
        chk("rest_first_cyc", bc[0], c0 + 1);
        chk("rest_cks", done_cks, 26);
        chk("rest_done_cnt", done_cnt, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
